// File: rtl/seg_disp_pkg.sv
// Shared constants and hex font for the seven-segment display blocks.
package seg_disp_pkg;

  localparam int NIB_W = 4;
  localparam int SEG_W = 8;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_OFF     = 8'hFF;
  localparam logic [SEG_W-1:0] SEG_DP_ONLY = 8'h7F;

  // Hex digit to active-low segments; dp (bit 7) is always returned off.
  function automatic logic [SEG_W-1:0] hex_font(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_hex_font.sv
// Combinational decoder: nibble + decimal point + blank -> active-low segments.
module seg_hex_font
  import seg_disp_pkg::*;
(
  input  logic [NIB_W-1:0] i_nib,
  input  logic             i_dp,
  input  logic             i_blank,
  output logic [SEG_W-1:0] o_seg
);

  // A blanked digit still shows its decimal point so fixed-point readouts keep their dot.
  always_comb begin
    if (i_blank) o_seg = i_dp ? SEG_DP_ONLY : SEG_OFF;
    else         o_seg = hex_font(i_nib) & {~i_dp, 7'h7F};
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment scanner with blanking, PWM brightness,
// leading-zero suppression and frame-synchronous double-buffered data.
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 65536,
  parameter int BLANK_CYC = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NIB_W*DIGITS-1:0] i_data_in,
  input  logic [DIGITS-1:0]       i_dp_in,
  input  logic                    i_data_vld,
  input  logic                    i_lz_en,
  input  logic [3:0]              i_bright,
  output logic                    o_frame_sync,
  output logic [DIGITS-1:0]       o_bit_code,
  output logic [SEG_W-1:0]        o_seg_code
);

  localparam int CNT_W   = $clog2(SCAN_DIV);
  localparam int IDX_W   = $clog2(DIGITS);
  localparam int SUB_DIV = SCAN_DIV / 16;
  localparam int SUB_W   = $clog2(SUB_DIV);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [SUB_W-1:0]        r_sub_cyc;
  logic [3:0]              r_sub;
  logic [NIB_W*DIGITS-1:0] r_pend, r_shad;
  logic [DIGITS-1:0]       r_pend_dp, r_shad_dp;
  logic                    r_pend_vld;
  logic                    r_frame_sync;
  logic [DIGITS-1:0]       r_bit_code;
  logic [SEG_W-1:0]        r_seg_code;

  logic                    w_slot_end, w_frame_end, w_sub_end, w_active;
  logic [DIGITS-1:0]       w_blank_vec, w_sel;
  logic                    w_zero_run;
  logic [SEG_W-1:0]        w_seg;

  assign w_slot_end  = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == IDX_W'(DIGITS - 1));
  assign w_sub_end   = (r_sub_cyc == SUB_W'(SUB_DIV - 1));
  // r_sub tracks cnt / (SCAN_DIV/16) without a divider
  assign w_active    = (r_cnt >= CNT_W'(BLANK_CYC)) && (r_sub <= i_bright);

  // Slot counter, PWM subphase and digit index
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sub_cyc <= '0;
      r_sub     <= '0;
    end else if (w_slot_end) begin
      r_cnt     <= '0;
      r_sub_cyc <= '0;
      r_sub     <= '0;
      r_idx     <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_sub_end) begin
        r_sub_cyc <= '0;
        r_sub     <= r_sub + 1'b1;
      end else begin
        r_sub_cyc <= r_sub_cyc + 1'b1;
      end
    end
  end

  // Pending/shadow buffers; a strobe on the boundary cycle lands in pending for next frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend       <= '0;
      r_pend_dp    <= '0;
      r_pend_vld   <= 1'b0;
      r_shad       <= '0;
      r_shad_dp    <= '0;
      r_frame_sync <= 1'b0;
    end else begin
      r_frame_sync <= w_frame_end;
      if (w_frame_end && r_pend_vld) begin
        r_shad    <= r_pend;
        r_shad_dp <= r_pend_dp;
      end
      if (i_data_vld) begin
        r_pend     <= i_data_in;
        r_pend_dp  <= i_dp_in;
        r_pend_vld <= 1'b1;
      end else if (w_frame_end) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  // Leading-zero mask (scan from the top digit down) and one-hot digit select
  always_comb begin
    w_blank_vec = '0;
    w_sel       = '0;
    w_zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_run     = w_zero_run && (r_shad[i*NIB_W +: NIB_W] == '0);
      w_blank_vec[i] = i_lz_en && (i != 0) && w_zero_run;
    end
    w_sel[r_idx] = 1'b1;
  end

  seg_hex_font u_font (
    .i_nib   (r_shad[NIB_W*int'(r_idx) +: NIB_W]),
    .i_dp    (r_shad_dp[r_idx]),
    .i_blank (w_blank_vec[r_idx]),
    .o_seg   (w_seg)
  );

  // Registered pin drivers; everything off outside the active window
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_code <= '1;
      r_seg_code <= SEG_OFF;
    end else begin
      r_bit_code <= w_active ? ~w_sel : '1;
      r_seg_code <= w_active ? w_seg : SEG_OFF;
    end
  end

  assign o_frame_sync = r_frame_sync;
  assign o_bit_code   = r_bit_code;
  assign o_seg_code   = r_seg_code;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (DIGITS=4, SCAN_DIV=32, BLANK_CYC=4).
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        data_vld, lz_en;
  logic [3:0]  bright;
  logic        frame_sync;
  logic [3:0]  bit_code;
  logic [7:0]  seg_code;

  int n_cmp = 0;
  int n_bad = 0;

  seg_scan_display #(.DIGITS(4), .SCAN_DIV(32), .BLANK_CYC(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data_in    (data_in),
    .i_dp_in      (dp_in),
    .i_data_vld   (data_vld),
    .i_lz_en      (lz_en),
    .i_bright     (bright),
    .o_frame_sync (frame_sync),
    .o_bit_code   (bit_code),
    .o_seg_code   (seg_code)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0]      br;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic strobe(input logic [15:0] d);
    data_in  = d;
    dp_in    = 4'h0;
    data_vld = 1'b1;
    tick;
    data_vld = 1'b0;
  endtask

  task automatic wait_fs(input string nm);
    int t = 0;
    while (frame_sync !== 1'b1 && t < 400) begin
      tick;
      t++;
    end
    chk(nm, 32'(frame_sync), 32'd1);
  endtask

  // Called when the DUT sits at cnt=0, idx=0; checks the next 128 samples.
  // Sample k reflects counter state k-1, so cnt=(k-1)%32 and idx=(k-1)/32.
  task automatic run_frame(input logic [3:0][7:0] exp, input logic [3:0] br, input string nm);
    int c, d;
    logic act;
    logic [3:0] one, eb;
    logic [7:0] es;
    one = 4'b0001;
    for (int k = 1; k <= 128; k++) begin
      tick;
      c   = (k - 1) % 32;
      d   = (k - 1) / 32;
      act = (c >= 4) && ((c / 2) <= int'(br));
      eb  = act ? ~(one << d) : 4'hF;
      es  = act ? exp[d] : 8'hFF;
      chk({nm, ".bit"}, 32'(bit_code), 32'(eb));
      chk({nm, ".seg"}, 32'(seg_code), 32'(es));
      chk({nm, ".fs"},  32'(frame_sync), (k == 128) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{16'h12AF, 4'b0000, 1'b0, 4'd15, {8'hF9, 8'hA4, 8'h88, 8'h8E}};
    vecs[1] = '{16'h0050, 4'b0100, 1'b1, 4'd15, {8'hFF, 8'h7F, 8'h92, 8'hC0}};
    vecs[2] = '{16'h0050, 4'b0100, 1'b0, 4'd15, {8'hC0, 8'h40, 8'h92, 8'hC0}};
    vecs[3] = '{16'h8001, 4'b1000, 1'b1, 4'd15, {8'h00, 8'hC0, 8'hC0, 8'hF9}};
    vecs[4] = '{16'h0000, 4'b0001, 1'b1, 4'd3,  {8'hFF, 8'hFF, 8'hFF, 8'h40}};
    vecs[5] = '{16'h0003, 4'b0000, 1'b1, 4'd0,  {8'hFF, 8'hFF, 8'hFF, 8'hB0}};

    rst_n = 1'b0; data_in = '0; dp_in = '0; data_vld = 1'b0; lz_en = 1'b0; bright = 4'd15;
    #23;
    chk("rst.bit", 32'(bit_code), 32'hF);
    chk("rst.seg", 32'(seg_code), 32'hFF);
    chk("rst.fs",  32'(frame_sync), 32'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick;
      chk($sformatf("boot%0d.bit", e), 32'(bit_code), (e == 5) ? 32'hE : 32'hF);
      chk($sformatf("boot%0d.seg", e), 32'(seg_code), (e == 5) ? 32'hC0 : 32'hFF);
    end

    // Table: strobe each vector, wait for it to reach the shadow, check a full frame
    for (int v = 0; v < 6; v++) begin
      lz_en    = vecs[v].lz;
      bright   = vecs[v].br;
      data_in  = vecs[v].data;
      dp_in    = vecs[v].dp;
      data_vld = 1'b1;
      tick;
      data_vld = 1'b0;
      wait_fs($sformatf("v%0d.wait", v));
      run_frame(vecs[v].exp, vecs[v].br, $sformatf("v%0d", v));
    end

    // Two strobes in the idx=1 slot: old data stays up, last strobe wins next frame
    bright = 4'd15;
    lz_en  = 1'b0;
    fork
      run_frame({8'hC0, 8'hC0, 8'hC0, 8'hB0}, 4'd15, "hold");
      begin
        repeat (40) tick;
        strobe(16'h1111);
        repeat (8) tick;
        strobe(16'h2222);
      end
    join

    // Pending 4444, then a strobe on the boundary cycle: 4444 shows first, 5555 a frame later
    fork
      run_frame({4{8'hA4}}, 4'd15, "last_wins");
      begin
        repeat (60) tick;
        strobe(16'h4444);
        repeat (66) tick;
        strobe(16'h5555);
      end
    join
    run_frame({4{8'h99}}, 4'd15, "pend_old");
    run_frame({4{8'h92}}, 4'd15, "deferred");

    // Asynchronous reset mid-slot with the clock held
    repeat (45) tick;
    chk("pre_rst.bit", 32'(bit_code), 32'hD);
    clk_run = 1'b0;
    #20;
    rst_n = 1'b0;
    #1;
    chk("arst.bit", 32'(bit_code), 32'hF);
    chk("arst.seg", 32'(seg_code), 32'hFF);
    chk("arst.fs",  32'(frame_sync), 32'd0);
    #20;
    rst_n = 1'b1;
    #3;
    clk_run = 1'b1;
    run_frame({4{8'hC0}}, 4'd15, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
